// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the word-to-byte memory controller.
// Used by mem_ctrl, the cache that drives it, and the bench.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        RW_NONE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } rw_flag_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // {found, idx}: lowest set mask bit at or above start
    function automatic logic [2:0] next_byte(
        input logic [3:0] mask,
        input logic [2:0] start
    );
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(start) && mask[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Splits 32-bit word requests into byte cycles on the external bus.
// Define MEM_CTRL_TIMEOUT_EN to abort a byte stuck on ext_ready.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_rw_flag,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_write_mask,
    output logic [31:0] mem_read_data,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err,
    output logic        ext_valid,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ready
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [2:0]  nb;
    logic        accept;
    logic        unused_ok;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign unused_ok = ^mem_addr[1:0];
`else
    assign unused_ok = ^{mem_addr[1:0], TIMEOUT_CYCLES};
`endif

    assign accept = (state_q != ST_XFER) && (mem_rw_flag != RW_NONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        nb      = 3'b000;
`ifdef MEM_CTRL_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    we_d    = (mem_rw_flag == RW_WRITE);
                    addr_d  = mem_addr[31:2];
                    data_d  = mem_write_data;
                    // reads walk all four bytes as if fully masked
                    mask_d  = we_d ? mem_write_mask : 4'hF;
                    nb      = next_byte(mask_d, 3'd0);
                    idx_d   = nb[1:0];
                    state_d = ST_XFER;
`ifdef MEM_CTRL_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ST_XFER: begin
                if (!valid_q) begin
                    state_d = ST_DONE;
                end else if (ext_ready) begin
                    if (!we_q) begin
                        rdata_d[{idx_q, 3'b000} +: 8] = ext_rdata;
                    end
                    nb = next_byte(mask_q, {1'b0, idx_q} + 3'd1);
                    if (nb[2]) begin
                        idx_d = nb[1:0];
`ifdef MEM_CTRL_TIMEOUT_EN
                        tmo_d = '0;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end
`ifdef MEM_CTRL_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_XFER);
        done_d  = (state_d == ST_DONE);
        valid_d = (state_d == ST_XFER) && mask_d[idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef MEM_CTRL_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign mem_read_data = rdata_q;
    assign mem_busy      = busy_q;
    assign mem_done      = done_q;
    assign mem_err       = err_q;
    assign ext_valid     = valid_q;
    assign ext_we        = valid_q & we_q;
    assign ext_addr      = {addr_q, idx_q};
    assign ext_wdata     = data_q[{idx_q, 3'b000} +: 8];

endmodule
